multiplicador_param: RTL and testbench

//   Parametrised sequential shift-and-add multiplier for the ALU datapath.

---
 rtl/mult_pkg.sv | 16 +
 rtl/multiplicador_dp.sv | 109 ++++++++++
 rtl/multiplicador_param.sv | 137 +++++++++++++
 tb/tb_multiplicador_param.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared constants for the shift-and-add multiplier: FSM state width and encodings.
// MULT_SIGNED_EN selects the two's-complement build; the FIX encoding is reserved either way.
package mult_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    FIX   = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/multiplicador_dp.sv
// Multiplier datapath: A/B shift registers, 2W-bit product accumulator and, when
// MULT_SIGNED_EN is defined, operand magnitude and result negation logic.
module multiplicador_dp
  import mult_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load_i,
  input  logic           add_i,
  input  logic           sh_i,
`ifdef MULT_SIGNED_EN
  input  logic           fix_i,
  input  logic           sgn_i,
`endif
  input  logic [W-1:0]   md_i,
  input  logic [W-1:0]   mr_i,
  output logic           b_zero_o,
  output logic           b_lsb_o,
  output logic [2*W-1:0] pp_o
);

  logic [2*W-1:0] a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [2*W-1:0] pp_q, pp_d;
  logic [W-1:0]   md_v, mr_v;

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;

  // The most negative value maps to 2^(W-1), which still fits in W unsigned bits.
  function automatic logic [W-1:0] abs_w(input logic [W-1:0] v);
    logic [W-1:0] r;
    if (v[W-1]) begin
      r = ~v + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction
`endif

  // Operand selection and next-state of A, B, pp (one control strobe active at a time).
  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    pp_d = pp_q;
    md_v = md_i;
    mr_v = mr_i;
`ifdef MULT_SIGNED_EN
    neg_d = neg_q;
    if (sgn_i) begin
      md_v = abs_w(md_i);
      mr_v = abs_w(mr_i);
    end else begin
      md_v = md_i;
      mr_v = mr_i;
    end
`endif
    if (load_i) begin
      a_d  = {{W{1'b0}}, md_v};
      b_d  = mr_v;
      pp_d = {(2*W){1'b0}};
`ifdef MULT_SIGNED_EN
      neg_d = sgn_i & (md_i[W-1] ^ mr_i[W-1]);
`endif
    end else if (add_i) begin
      pp_d = pp_q + a_q;
    end else if (sh_i) begin
      a_d = a_q << 1;
      b_d = b_q >> 1;
`ifdef MULT_SIGNED_EN
    end else if (fix_i) begin
      if (neg_q) begin
        pp_d = ~pp_q + {{(2*W-1){1'b0}}, 1'b1};
      end else begin
        pp_d = pp_q;
      end
`endif
    end else begin
      pp_d = pp_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= {(2*W){1'b0}};
      b_q   <= {W{1'b0}};
      pp_q  <= {(2*W){1'b0}};
`ifdef MULT_SIGNED_EN
      neg_q <= 1'b0;
`endif
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      pp_q  <= pp_d;
`ifdef MULT_SIGNED_EN
      neg_q <= neg_d;
`endif
    end
  end

  assign b_zero_o = (b_q == {W{1'b0}});
  assign b_lsb_o  = b_q[0];
  assign pp_o     = pp_q;

endmodule

// File: rtl/multiplicador_param.sv
// Sequential shift-and-add multiplier with early termination and busy/done status.
// Defining MULT_SIGNED_EN adds the sgn port and the FIX state for two's-complement operands.
module multiplicador_param
  import mult_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           init,
  input  logic [W-1:0]   MD,
  input  logic [W-1:0]   MR,
`ifdef MULT_SIGNED_EN
  input  logic           sgn,
`endif
  output logic [2*W-1:0] pp,
  output logic           busy,
  output logic           done
);

  state_t state_q, state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   load_s, add_s, sh_s;
  logic   b_zero_s, b_lsb_s;

`ifdef MULT_SIGNED_EN
  logic sgn_q, sgn_d;
  logic fix_s;
`endif

  multiplicador_dp #(
    .W (W)
  ) u_dp (
    .clk      (clk),
    .reset    (reset),
    .load_i   (load_s),
    .add_i    (add_s),
    .sh_i     (sh_s),
`ifdef MULT_SIGNED_EN
    .fix_i    (fix_s),
    .sgn_i    (sgn),
`endif
    .md_i     (MD),
    .mr_i     (MR),
    .b_zero_o (b_zero_s),
    .b_lsb_o  (b_lsb_s),
    .pp_o     (pp)
  );

  // Next-state, datapath strobes and registered status derived from the next state.
  always_comb begin
    state_d = state_q;
    load_s  = 1'b0;
    add_s   = 1'b0;
    sh_s    = 1'b0;
`ifdef MULT_SIGNED_EN
    fix_s   = 1'b0;
    sgn_d   = sgn_q;
`endif
    case (state_q)
      IDLE: begin
        if (init) begin
          load_s  = 1'b1;
          state_d = CHECK;
`ifdef MULT_SIGNED_EN
          sgn_d   = sgn;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (b_zero_s) begin
`ifdef MULT_SIGNED_EN
          if (sgn_q) begin
            state_d = FIX;
          end else begin
            state_d = DONE;
          end
`else
          state_d = DONE;
`endif
        end else if (b_lsb_s) begin
          state_d = ADD;
        end else begin
          state_d = SHIFT;
        end
      end
      ADD: begin
        add_s   = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        sh_s    = 1'b1;
        state_d = CHECK;
      end
`ifdef MULT_SIGNED_EN
      FIX: begin
        fix_s   = 1'b1;
        state_d = DONE;
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // FSM state and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULT_SIGNED_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MULT_SIGNED_EN
      sgn_q   <= sgn_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_multiplicador_param.sv
// Directed, table-driven bench for multiplicador_param (W=8); signed vectors only
// when MULT_SIGNED_EN is defined.
module tb_multiplicador_param;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0]   md;
    logic [W-1:0]   mr;
    logic           sg;
    logic [2*W-1:0] pp;
    int             lat;
  } vec_t;

  logic           clk;
  logic           reset;
  logic           init;
  logic [W-1:0]   MD;
  logic [W-1:0]   MR;
`ifdef MULT_SIGNED_EN
  logic           sgn;
`endif
  logic [2*W-1:0] pp;
  logic           busy;
  logic           done;

  int   n_tests;
  int   n_fail;
  vec_t vecs [0:15];
  int   n_vec;

  multiplicador_param #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .init  (init),
    .MD    (MD),
    .MR    (MR),
`ifdef MULT_SIGNED_EN
    .sgn   (sgn),
`endif
    .pp    (pp),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic [W-1:0] md, input logic [W-1:0] mr, input logic sg,
                         input logic [2*W-1:0] p, input int lat);
    vecs[n_vec] = '{md: md, mr: mr, sg: sg, pp: p, lat: lat};
    n_vec++;
  endtask

  task automatic set_sgn(input logic s);
`ifdef MULT_SIGNED_EN
    sgn = s;
`else
    if (s) $display("note: signed vector skipped in unsigned build");
`endif
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    lat = 0;
    @(negedge clk);
    MD = v.md; MR = v.mr; set_sgn(v.sg); init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    MD = 8'hA5; MR = 8'h5A; set_sgn(~v.sg);
    chk({nm, " busy after init"}, {31'd0, busy}, 32'd1);
    for (int c = 1; c <= 100 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (done) lat = c;
    end
    chk({nm, " latency"}, lat, v.lat);
    chk({nm, " pp"}, {16'd0, pp}, {16'd0, v.pp});
    @(posedge clk); #1;
    chk({nm, " idle after done"}, {30'd0, busy, done}, 32'd0);
    chk({nm, " pp held"}, {16'd0, pp}, {16'd0, v.pp});
  endtask

  initial begin
    int dcnt;
    int first;
    n_tests = 0; n_fail = 0; n_vec = 0;
    reset = 1'b0; init = 1'b0; MD = 8'd0; MR = 8'd0; set_sgn(1'b0);

    // latency = 2*bitlen(MR) + popcount(MR) + 1 (+1 for FIX when sgn=1)
    add_vec(8'd3,   8'd5,   1'b0, 16'd15,    9);
    add_vec(8'd255, 8'd255, 1'b0, 16'hFE01,  25);
    add_vec(8'd200, 8'd0,   1'b0, 16'd0,     1);
    add_vec(8'd0,   8'd255, 1'b0, 16'd0,     25);
    add_vec(8'd1,   8'd128, 1'b0, 16'd128,   18);
    add_vec(8'd170, 8'd85,  1'b0, 16'd14450, 19);
    add_vec(8'd255, 8'd1,   1'b0, 16'd255,   4);
    add_vec(8'hFD,  8'd5,   1'b0, 16'h04F1,  9);
`ifdef MULT_SIGNED_EN
    add_vec(8'hFD,  8'd5,   1'b1, 16'hFFF1,  10);
    add_vec(8'h80,  8'hFF,  1'b1, 16'h0080,  5);
    add_vec(8'h80,  8'h80,  1'b1, 16'h4000,  19);
    add_vec(8'd5,   8'hFD,  1'b1, 16'hFFF1,  8);
    add_vec(8'h85,  8'd0,   1'b1, 16'd0,     2);
`endif

    #12;
    chk("reset pp", {16'd0, pp}, 32'd0);
    chk("reset busy/done", {30'd0, busy, done}, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("idle after reset", {30'd0, busy, done}, 32'd0);

    for (int i = 0; i < n_vec; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // init requests while busy and during DONE must be ignored
    @(negedge clk);
    MD = 8'd7; MR = 8'd9; set_sgn(1'b0); init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    dcnt = 0; first = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      init = 1'b0;
      if (c == 2) begin
        init = 1'b1; MD = 8'd2; MR = 8'd2;
      end
      if (done) begin
        dcnt++;
        if (first == 0) first = c;
        init = 1'b1; MD = 8'd2; MR = 8'd2;
      end
    end
    init = 1'b0;
    chk("busy-init done count", dcnt, 32'd1);
    chk("busy-init latency", first, 32'd11);
    chk("busy-init pp", {16'd0, pp}, 32'd63);
    chk("busy-init idle", {31'd0, busy}, 32'd0);

    // asynchronous reset mid-operation
    @(negedge clk);
    MD = 8'd255; MR = 8'd255; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid-op pp", {16'd0, pp}, 32'd255);
    chk("mid-op busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("async reset pp", {16'd0, pp}, 32'd0);
    chk("async reset busy/done", {30'd0, busy, done}, 32'd0);
    @(negedge clk); reset = 1'b1;
    run_vec('{md: 8'd4, mr: 8'd6, sg: 1'b0, pp: 16'd24, lat: 9}, "after reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
